uni_bitstream_decoder: RTL and testbench

Converts a unipolar stochastic bitstream, such as the `oC` output of the 16-input temporal MAC array, back into a binary value. It counts the ones over a fixed window of 2^BW valid bits and presents the saturated count as a BW-bit result. The result is held under a valid/ready handshake. It sits at the output end of the stochastic compute chain, ahead of any binary post-processing or readback logic.

---
 rtl/uni_bitstream_decoder_if.sv | 12 +
 rtl/uni_bitstream_decoder.sv | 52 +++++
 tb/tb_uni_bitstream_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uni_bitstream_decoder_if.sv
// uni_bitstream_decoder_if: stream input, start control and result handshake of the bitstream decoder
interface uni_bitstream_decoder_if #(parameter int BW = 8);
  logic          start;
  logic          iEn;
  logic          iBit;
  logic          oReady;
  logic          oValid;
  logic [BW-1:0] oData;
  logic          oBusy;
  modport master (output start, iEn, iBit, oReady, input oValid, oData, oBusy);
  modport slave  (input start, iEn, iBit, oReady, output oValid, oData, oBusy);
endinterface

// File: rtl/uni_bitstream_decoder.sv
// uni_bitstream_decoder: counts ones over a 2^BW valid-bit window and holds the saturated count
module uni_bitstream_decoder #(parameter int BW = 8) (
  input logic                clk,
  input logic                rst_n,
  uni_bitstream_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  localparam logic [BW:0] LAST = {1'b0, {BW{1'b1}}};
  state_t        state_q, state_d;
  logic [BW:0]   bit_cnt_q, bit_cnt_d, ones_cnt_q, ones_cnt_d, sum;
  logic [BW-1:0] data_q, data_d;
  logic          clr;
  assign sum = ones_cnt_q + (BW+1)'(bus.iBit);
  // start is honoured everywhere except in HOLD without a consumer, so the result is never dropped
  assign clr = bus.start && (state_q != HOLD || bus.oReady);
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    data_d     = data_q;
    if (clr) begin
      state_d    = ACC;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end else if (state_q == ACC && bus.iEn) begin
      bit_cnt_d  = bit_cnt_q + (BW+1)'(1);
      ones_cnt_d = sum;
      if (bit_cnt_q == LAST) begin
        data_d  = sum[BW] ? '1 : sum[BW-1:0];
        state_d = HOLD;
      end
    end else if (state_q == HOLD && bus.oReady) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      data_q     <= data_d;
    end
  end
  assign bus.oValid = state_q == HOLD;
  assign bus.oBusy  = state_q == ACC;
  assign bus.oData  = data_q;
endmodule

// File: tb/tb_uni_bitstream_decoder.sv
// tb_uni_bitstream_decoder: directed windows with a result scoreboard popped on each accepted handshake
module tb_uni_bitstream_decoder;
  logic clk = 0;
  logic rst_n = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_q[$];
  uni_bitstream_decoder_if #(.BW(8)) bus ();
  uni_bitstream_decoder #(.BW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.oValid && bus.oReady) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result_data", int'(bus.oData), exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1;
    step();
    bus.start = 0;
    chk("busy_after_start", int'(bus.oBusy), 1);
  endtask

  task automatic feed(input logic [255:0] pat, input int gaps);
    for (int i = 0; i < 256; i++) begin
      if (gaps > 0 && $urandom_range(0, 1) == 1) begin
        bus.iEn = 0;
        bus.iBit = 1;
        step();
        gaps--;
      end
      bus.iEn = 1;
      bus.iBit = pat[i];
      if (i == 255) chk("valid_before_last", int'(bus.oValid), 0);
      step();
    end
    bus.iEn = 0;
    bus.iBit = 0;
    chk("valid_after_last", int'(bus.oValid), 1);
    chk("busy_after_last", int'(bus.oBusy), 0);
  endtask

  initial begin
    bus.start = 0;
    bus.iEn = 0;
    bus.iBit = 0;
    bus.oReady = 1;
    #12;
    chk("reset_valid", int'(bus.oValid), 0);
    chk("reset_busy", int'(bus.oBusy), 0);
    chk("reset_data", int'(bus.oData), 0);
    rst_n = 1;
    step();
    // all ones saturates to 255 and valid lasts one cycle
    exp_q.push_back(255);
    do_start();
    feed('1, 0);
    step();
    chk("valid_one_cycle", int'(bus.oValid), 0);
    chk("idle_busy", int'(bus.oBusy), 0);
    // alternating starting with 1, then all zeros
    exp_q.push_back(128);
    do_start();
    feed({128{2'b01}}, 0);
    step();
    exp_q.push_back(0);
    do_start();
    feed('0, 0);
    step();
    // 64 ones with 100 gap cycles presenting iBit=1
    exp_q.push_back(64);
    do_start();
    feed({64{4'b0001}}, 100);
    step();
    // backpressure in HOLD, then accept with start in the same cycle
    bus.oReady = 0;
    exp_q.push_back(192);
    do_start();
    feed({64{4'b0111}}, 0);
    for (int i = 0; i < 10; i++) begin
      bus.start = i[0];
      bus.iEn = 1;
      bus.iBit = ~bus.iBit;
      step();
      chk("hold_valid", int'(bus.oValid), 1);
      chk("hold_data", int'(bus.oData), 192);
    end
    bus.iEn = 0;
    bus.start = 1;
    bus.oReady = 1;
    step();
    bus.start = 0;
    chk("restart_valid", int'(bus.oValid), 0);
    chk("restart_busy", int'(bus.oBusy), 1);
    exp_q.push_back(16);
    feed({16{16'h0001}}, 0);
    step();
    // restart mid-window discards the earlier ones and the start-cycle bit
    exp_q.push_back(32);
    do_start();
    for (int i = 0; i < 100; i++) begin
      bus.iEn = 1;
      bus.iBit = 1;
      step();
    end
    bus.start = 1;
    step();
    bus.start = 0;
    feed({32{8'h01}}, 0);
    step();
    // asynchronous reset during ACC
    do_start();
    for (int i = 0; i < 150; i++) begin
      bus.iEn = 1;
      bus.iBit = 1;
      step();
    end
    #2 rst_n = 0;
    #1;
    chk("rst_acc_busy", int'(bus.oBusy), 0);
    chk("rst_acc_valid", int'(bus.oValid), 0);
    chk("rst_acc_data", int'(bus.oData), 0);
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", int'(bus.oValid), 0);
      chk("post_rst_busy", int'(bus.oBusy), 0);
    end
    // asynchronous reset during HOLD
    bus.oReady = 0;
    do_start();
    feed({128{2'b10}}, 0);
    chk("hold_pre_rst_data", int'(bus.oData), 128);
    #2 rst_n = 0;
    #1;
    chk("rst_hold_valid", int'(bus.oValid), 0);
    chk("rst_hold_data", int'(bus.oData), 0);
    chk("rst_hold_busy", int'(bus.oBusy), 0);
    #3 rst_n = 1;
    bus.oReady = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst2_valid", int'(bus.oValid), 0);
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
